// File: rtl/rv_hazard_stall_ctrl.sv
// Hazard and stall controller for a 5-stage RISC-V pipeline: operand forwarding,
// load-use interlock, branch flush and a DMEM handshake with timeout.
module rv_hazard_stall_ctrl #(
  parameter int REGADDR_W = 5,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REGADDR_W-1:0] rs1_d,
  input  logic [REGADDR_W-1:0] rs2_d,
  input  logic [REGADDR_W-1:0] rs1_e,
  input  logic [REGADDR_W-1:0] rs2_e,
  input  logic [REGADDR_W-1:0] rd_e,
  input  logic [REGADDR_W-1:0] rd_m,
  input  logic [REGADDR_W-1:0] rd_w,
  input  logic                 regwrite_e,
  input  logic                 regwrite_m,
  input  logic                 regwrite_w,
  input  logic                 load_e,
  input  logic                 pcsrc_e,
  input  logic                 mem_access_m,
  input  logic                 dmem_ack,
  output logic                 dmem_req,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 stall_e,
  output logic                 stall_m,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic                 flush_w,
  output logic                 mem_err,
  output logic [1:0]           forward_a_e,
  output logic [1:0]           forward_b_e,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               mstall;
  logic               lu;

  // M stage wins over W because it holds the younger result.
  function automatic logic [1:0] fwd_sel(input logic [REGADDR_W-1:0] rs);
    if (regwrite_m && (rd_m == rs) && (rd_m != '0))      return 2'b10;
    else if (regwrite_w && (rd_w == rs) && (rd_w != '0)) return 2'b01;
    else                                                 return 2'b00;
  endfunction

  assign forward_a_e = fwd_sel(rs1_e);
  assign forward_b_e = fwd_sel(rs2_e);

  assign lu = load_e && regwrite_e && (rd_e != '0) &&
              ((rd_e == rs1_d) || (rd_e == rs2_d));

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    dmem_req = 1'b0;
    mstall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        dmem_req = mem_access_m;
        if (mem_access_m && !dmem_ack) begin
          state_d = S_WAIT;
          wcnt_d  = WCNT_W'(1);
          mstall  = 1'b1;
        end
      end
      S_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end else begin
          mstall = 1'b1;
          if (wcnt_q == WCNT_W'(TIMEOUT)) state_d = S_ERR;
          else                            wcnt_d  = wcnt_q + WCNT_W'(1);
        end
      end
      S_ERR:   mstall  = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_err = (state_q == S_ERR);

  // Memory stall freezes the whole pipe; a taken branch beats a load-use bubble.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (mstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pcsrc_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_f && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/rv_hazard_stall_ctrl.md
RV_HAZARD_STALL_CTRL -- requirements
Module: rv_hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter REGADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum DMEM wait cycles before error (legal 2..65535).
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have ports `clk in 1` (clock) and `rst_n in 1` (reset); one clock, reset is asynchronous and active-low.
REQ-005 SHALL have inputs `rs1_d`, `rs2_d`, `rs1_e`, `rs2_e`, `rd_e`, `rd_m`, `rd_w`, each REGADDR_W wide: register addresses per stage.
REQ-006 SHALL have 1-bit inputs `regwrite_e`, `regwrite_m`, `regwrite_w`, `load_e` (E instr is a load), `pcsrc_e` (taken branch/jump in E), `mem_access_m` (load/store in M), `dmem_ack` (DMEM completes access).
REQ-007 SHALL have 1-bit outputs `dmem_req`, `stall_f`, `stall_d`, `stall_e`, `stall_m`, `flush_d`, `flush_e`, `flush_w` (bubble into W), `mem_err` (sticky timeout).
REQ-008 SHALL have outputs `forward_a_e` and `forward_b_e`, 2 bits each (00 regfile, 01 W result, 10 M ALU result), and `stall_cnt`, CNT_W bits.

Function
REQ-009 Forwarding SHALL be combinational: select 10 if `regwrite_m` and `rd_m`==rsX_e and `rd_m`!=0; else 01 if `regwrite_w` and `rd_w`==rsX_e and `rd_w`!=0; else 00. M has priority over W.
REQ-010 Load-use hazard (`lu`) SHALL be `load_e` & `regwrite_e` & `rd_e`!=0 & (`rd_e`==`rs1_d` | `rd_e`==`rs2_d`).
REQ-011 Memory-handshake FSM SHALL have states IDLE, WAIT, ERR, with a wait counter of ceil(log2(TIMEOUT+1)) bits.
REQ-012 IDLE: `dmem_req`=`mem_access_m`. If `mem_access_m` & `dmem_ack`, the access is zero-wait and the FSM stays in IDLE. If `mem_access_m` & !`dmem_ack`, the FSM goes to WAIT with counter=1.
REQ-013 WAIT: `dmem_req`=1. On `dmem_ack`, go to IDLE and clear the counter. Else, if counter==TIMEOUT, go to ERR. Else increment the counter.
REQ-014 ERR: `dmem_req`=0 and `mem_err`=1; the FSM stays in ERR until reset.
REQ-015 `mstall` SHALL be 1 in IDLE when `mem_access_m` & !`dmem_ack`, 1 in WAIT when !`dmem_ack`, and 1 in ERR always.
REQ-016 When `mstall`=1: `stall_f`=`stall_d`=`stall_e`=`stall_m`=1, `flush_w`=1, and `flush_d`=`flush_e`=0. `mstall` overrides `lu` and `pcsrc_e`.
REQ-017 When !`mstall` & `pcsrc_e`: `flush_d`=`flush_e`=1, all stalls 0. The branch overrides a simultaneous `lu`.
REQ-018 When !`mstall` & !`pcsrc_e` & `lu`: `stall_f`=`stall_d`=1, `flush_e`=1, and all other stall/flush outputs 0.
REQ-019 Otherwise all stall and flush outputs SHALL be 0.
REQ-020 `stall_cnt` SHALL increment by 1 on each clock edge where `stall_f`=1, and saturate at all-ones.
REQ-021 All stall, flush and forward outputs SHALL be combinational from inputs and FSM state, with zero latency.
REQ-022 State, wait counter and `stall_cnt` SHALL be the only registers.

Reset
REQ-023 While `rst_n`=0: FSM in IDLE, wait counter=0, `stall_cnt`=0, `mem_err`=0, applied asynchronously.
REQ-024 With all inputs 0 during reset, every output SHALL be 0.
REQ-025 Reset asserted in WAIT or ERR SHALL drop `dmem_req` and `mem_err` in the same cycle.
REQ-026 After reset release, the first active edge SHALL be evaluated normally.

Verification
REQ-027 Forwarding: `rs1_e`=5, `rd_m`=5, `rd_w`=5, `regwrite_m`=`regwrite_w`=1 -> `forward_a_e`=10. Set `regwrite_m`=0 -> 01. Set `rd_m`=`rd_w`=0 -> 00.
REQ-028 Load-use: `load_e`=1, `regwrite_e`=1, `rd_e`=7, `rs2_d`=7 -> `stall_f`=`stall_d`=`flush_e`=1 for one cycle. Add `pcsrc_e`=1 -> `flush_d`=`flush_e`=1, `stall_f`=0.
REQ-029 DMEM wait: `mem_access_m`=1 with `dmem_ack` held 0 for 3 cycles, then 1 -> `dmem_req`=1 for 4 cycles, all stalls and `flush_w`=1 for 3 cycles, stalls 0 on the ack cycle, `stall_cnt`=3.
REQ-030 Timeout with TIMEOUT=4: `mem_access_m`=1, no ack -> ERR entered after the counter reaches 4; `mem_err`=1, `dmem_req`=0, stalls held 1; a later `dmem_ack`=1 is ignored.
REQ-031 Reset mid-WAIT: `rst_n`=0 in the 2nd wait cycle -> `dmem_req`=0 and `stall_cnt`=0 immediately; after release with `mem_access_m`=0, all outputs 0.
REQ-032 Saturation with CNT_W=4: force 20 stall cycles -> `stall_cnt`=15 and holds at 15.
